// File: rtl/axi_sub_pkg.sv
// Shared widths, burst length and FSM encodings for the SRAM-backed AXI-style subordinate.
package axi_sub_pkg;
  localparam int BEATS  = 4;
  localparam int ID_W   = 4;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;
endpackage

// File: rtl/axi_sub_ram.sv
// Simple dual-port SRAM: byte-enabled write port, registered read-first read port.
module axi_sub_ram
  import axi_sub_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rdata_q;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (we_i && wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_sram_subordinate.sv
// Fixed 4-beat x 32-bit burst subordinate backed by an internal SRAM, independent W and R paths.
//   state   | meaning
//   W_IDLE  | awready high, waiting for a write request
//   W_DATA  | wready high, writing beats into the line
//   W_RESP  | bvalid high until bready
//   R_IDLE  | arready high, waiting for a read request
//   R_FETCH | one-cycle SRAM read of the current beat
//   R_DATA  | rvalid high with registered RAM data until rready
module axi_sram_subordinate
  import axi_sub_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [5:0]        awatop,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID_W-1:0]   bid,
  output logic              bcomp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic              rlast
);
  localparam int WORD_AW = MEM_AW + CNT_W;

  w_state_e          w_state_q;
  logic              awready_q, wready_q, bvalid_q, bcomp_q;
  logic [ID_W-1:0]   bid_q;
  logic [MEM_AW-1:0] wline_q;
  logic [CNT_W-1:0]  wcnt_q;

  r_state_e          r_state_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [ID_W-1:0]   rid_q;
  logic [MEM_AW-1:0] rline_q;
  logic [CNT_W-1:0]  rcnt_q;

  logic wr_beat;
  assign wr_beat = wvalid && wready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bcomp_q   <= 1'b0;
      bid_q     <= '0;
      wline_q   <= '0;
      wcnt_q    <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (awvalid && awready_q) begin
            bid_q     <= awid;
            wline_q   <= awaddr[MEM_AW+3:4];
            wcnt_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (wr_beat) begin
            wcnt_q <= wcnt_q + 1'b1;
            // A burst is cut short by an early wlast, and never runs past the line.
            if (wlast || (wcnt_q == LAST_BEAT)) begin
              bcomp_q   <= wlast && (wcnt_q == LAST_BEAT);
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rline_q   <= '0;
      rcnt_q    <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (arvalid && arready_q) begin
            rid_q     <= arid;
            rline_q   <= araddr[MEM_AW+3:4];
            rcnt_q    <= '0;
            arready_q <= 1'b0;
            r_state_q <= R_FETCH;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_FETCH: begin
          rvalid_q  <= 1'b1;
          rlast_q   <= (rcnt_q == LAST_BEAT);
          r_state_q <= R_DATA;
        end
        R_DATA: begin
          if (rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              r_state_q <= R_IDLE;
            end else begin
              rcnt_q    <= rcnt_q + 1'b1;
              r_state_q <= R_FETCH;
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  axi_sub_ram #(.AW(WORD_AW)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_beat),
    .waddr_i ({wline_q, wcnt_q}),
    .wdata_i (wdata),
    .wstrb_i (wstrb),
    .re_i    (r_state_q == R_FETCH),
    .raddr_i ({rline_q, rcnt_q}),
    .rdata_o (rdata)
  );

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bcomp   = bcomp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rlast   = rlast_q;

  logic unused_ok;
  assign unused_ok = ^{awatop, awaddr[31:MEM_AW+4], awaddr[3:0],
                       araddr[31:MEM_AW+4], araddr[3:0]};
endmodule
